// File: rtl/akuma_anim_ctrl.sv
// -----------------------------------------------------------------------------
// akuma_anim_ctrl
//   Per-frame motion and animation sequencer for the Akuma sprite. On every
//   frame_tick the player command levels are turned into a new sprite
//   position, facing direction, action state and animation frame index.
//   Nothing changes between ticks; every output is a flop.
//
// Ports
//   vga_clk        pixel clock, all logic on its rising edge
//   Reset          synchronous, active-high; wins over frame_tick
//   frame_tick     one-cycle pulse per video frame
//   move_left/right, punch, kick, jump   level commands
//   AkumaX/AkumaY  sprite top-left corner (px)
//   facing_left    1 = left-facing sprite set
//   anim_state     0 IDLE, 1 WALK, 2 PUNCH, 3 KICK, 4 JUMP_UP, 5 JUMP_DOWN
//   anim_frame     frame index within the current state
//   attack_active  hit window for collision logic
//   busy           high in PUNCH/KICK/JUMP_UP/JUMP_DOWN
// -----------------------------------------------------------------------------
module akuma_anim_ctrl #(
  parameter int X_START         = 100,
  parameter int X_MIN           = 0,
  parameter int X_MAX           = 498,
  parameter int GROUND_Y        = 240,
  parameter int WALK_STEP       = 4,
  parameter int JUMP_STEP       = 8,
  parameter int JUMP_HEIGHT     = 96,
  parameter int TICKS_PER_FRAME = 6,
  parameter int PUNCH_FRAMES    = 3,
  parameter int KICK_FRAMES     = 4
) (
  input  logic       vga_clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       punch,
  input  logic       kick,
  input  logic       jump,
  output logic [9:0] AkumaX,
  output logic [9:0] AkumaY,
  output logic       facing_left,
  output logic [2:0] anim_state,
  output logic [2:0] anim_frame,
  output logic       attack_active,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WALK      = 3'd1,
    ST_PUNCH     = 3'd2,
    ST_KICK      = 3'd3,
    ST_JUMP_UP   = 3'd4,
    ST_JUMP_DOWN = 3'd5
  } state_t;

  localparam int TICK_W = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICKS_PER_FRAME - 1);

  localparam logic signed [10:0] X_MIN_S  = 11'(X_MIN);
  localparam logic signed [10:0] X_MAX_S  = 11'(X_MAX);
  localparam logic signed [10:0] GROUND_S = 11'(GROUND_Y);
  localparam logic signed [10:0] APEX_S   = 11'(GROUND_Y - JUMP_HEIGHT);
  localparam logic signed [10:0] WALK_S   = 11'(WALK_STEP);
  localparam logic signed [10:0] JUMP_S   = 11'(JUMP_STEP);

  localparam logic [9:0] X_RESET = 10'(X_START);
  localparam logic [9:0] Y_RESET = 10'(GROUND_Y);

  localparam logic [2:0] IDLE_LAST  = 3'd1;
  localparam logic [2:0] WALK_LAST  = 3'd3;
  localparam logic [2:0] PUNCH_LAST = 3'(PUNCH_FRAMES - 1);
  localparam logic [2:0] KICK_LAST  = 3'(KICK_FRAMES - 1);
  localparam logic [2:0] PUNCH_HIT  = 3'd1;
  localparam logic [2:0] KICK_HIT   = 3'd2;

  state_t            state_q, state_d;
  logic [9:0]        x_q, x_d, y_q, y_d;
  logic              facing_q, facing_d;
  logic [2:0]        frame_q, frame_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic              attack_q, attack_d;
  logic              busy_q, busy_d;

  logic              dir_valid, tick_wrap;
  logic signed [10:0] x_ext, y_ext, x_moved, x_clamped, y_up, y_down;
  logic [2:0]        loop_last, act_last;

  // Shared datapath: signed 11-bit so a step past 0 goes negative and clamps
  // instead of wrapping.
  always_comb begin
    dir_valid = move_left ^ move_right;
    x_ext     = signed'({1'b0, x_q});
    y_ext     = signed'({1'b0, y_q});
    x_moved   = move_left ? (x_ext - WALK_S) : (x_ext + WALK_S);
    if (x_moved < X_MIN_S)
      x_clamped = X_MIN_S;
    else if (x_moved > X_MAX_S)
      x_clamped = X_MAX_S;
    else
      x_clamped = x_moved;
    y_up      = y_ext - JUMP_S;
    y_down    = y_ext + JUMP_S;
    tick_wrap = (tick_q == TICK_MAX);
    loop_last = (state_q == ST_WALK) ? WALK_LAST : IDLE_LAST;
    act_last  = (state_q == ST_PUNCH) ? PUNCH_LAST : KICK_LAST;
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    facing_d = facing_q;
    frame_d  = frame_q;
    tick_d   = tick_q;

    if (frame_tick) begin
      case (state_q)
        ST_IDLE, ST_WALK: begin
          if (jump) begin
            state_d = ST_JUMP_UP;
            tick_d  = '0;
            frame_d = '0;
          end else if (punch) begin
            state_d = ST_PUNCH;
            tick_d  = '0;
            frame_d = '0;
          end else if (kick) begin
            state_d = ST_KICK;
            tick_d  = '0;
            frame_d = '0;
          end else begin
            state_d = dir_valid ? ST_WALK : ST_IDLE;
            if (dir_valid) begin
              x_d      = x_clamped[9:0];
              facing_d = move_left;
            end
            // IDLE<->WALK swaps restart the loop; staying keeps animating.
            if (state_d != state_q) begin
              tick_d  = '0;
              frame_d = '0;
            end else if (tick_wrap) begin
              tick_d  = '0;
              frame_d = (frame_q == loop_last) ? 3'd0 : frame_q + 3'd1;
            end else begin
              tick_d = tick_q + 1'b1;
            end
          end
        end

        ST_PUNCH, ST_KICK: begin
          // Commands and position frozen; leave on the last tick of the last frame.
          if (tick_wrap && (frame_q == act_last)) begin
            state_d = ST_IDLE;
            tick_d  = '0;
            frame_d = '0;
          end else if (tick_wrap) begin
            tick_d  = '0;
            frame_d = frame_q + 3'd1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end

        ST_JUMP_UP: begin
          if (dir_valid) x_d = x_clamped[9:0];
          if (y_up <= APEX_S) begin
            y_d     = APEX_S[9:0];
            state_d = ST_JUMP_DOWN;
            tick_d  = '0;
            frame_d = 3'd1;
          end else begin
            y_d = y_up[9:0];
          end
        end

        ST_JUMP_DOWN: begin
          if (dir_valid) x_d = x_clamped[9:0];
          if (y_down >= GROUND_S) begin
            y_d     = GROUND_S[9:0];
            state_d = ST_IDLE;
            tick_d  = '0;
            frame_d = '0;
          end else begin
            y_d = y_down[9:0];
          end
        end

        default: begin
          state_d = ST_IDLE;
          tick_d  = '0;
          frame_d = '0;
        end
      endcase
    end

    // Decoded from next-state values so they line up with anim_state/frame.
    attack_d = ((state_d == ST_PUNCH) && (frame_d == PUNCH_HIT)) ||
               ((state_d == ST_KICK)  && (frame_d == KICK_HIT));
    busy_d   = (state_d == ST_PUNCH) || (state_d == ST_KICK) ||
               (state_d == ST_JUMP_UP) || (state_d == ST_JUMP_DOWN);
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      x_q      <= X_RESET;
      y_q      <= Y_RESET;
      facing_q <= 1'b0;
      frame_q  <= '0;
      tick_q   <= '0;
      attack_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      facing_q <= facing_d;
      frame_q  <= frame_d;
      tick_q   <= tick_d;
      attack_q <= attack_d;
      busy_q   <= busy_d;
    end
  end

  assign AkumaX        = x_q;
  assign AkumaY        = y_q;
  assign facing_left   = facing_q;
  assign anim_state    = state_q;
  assign anim_frame    = frame_q;
  assign attack_active = attack_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_akuma_anim_ctrl.sv
// -----------------------------------------------------------------------------
// tb_akuma_anim_ctrl
//   Drives akuma_anim_ctrl with directed scenarios and a randomized command
//   stream. A tick-level model (ticks since state entry, plain integer
//   position) predicts every output; a negedge process compares each cycle,
//   and literal values pin the model at known points of each scenario.
// -----------------------------------------------------------------------------
module tb_akuma_anim_ctrl;

  logic       vga_clk = 1'b0;
  logic       Reset, frame_tick, move_left, move_right, punch, kick, jump;
  logic [9:0] AkumaX, AkumaY;
  logic       facing_left;
  logic [2:0] anim_state, anim_frame;
  logic       attack_active, busy;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model state: position, facing, state code and ticks since entering it.
  int m_x, m_y, m_face, m_st, m_t;

  always #5 vga_clk = ~vga_clk;

  akuma_anim_ctrl dut (
    .vga_clk       (vga_clk),
    .Reset         (Reset),
    .frame_tick    (frame_tick),
    .move_left     (move_left),
    .move_right    (move_right),
    .punch         (punch),
    .kick          (kick),
    .jump          (jump),
    .AkumaX        (AkumaX),
    .AkumaY        (AkumaY),
    .facing_left   (facing_left),
    .anim_state    (anim_state),
    .anim_frame    (anim_frame),
    .attack_active (attack_active),
    .busy          (busy)
  );

  function automatic int clampx(input int v);
    if (v < 0) return 0;
    if (v > 498) return 498;
    return v;
  endfunction

  function automatic int exp_frame();
    case (m_st)
      0:       return (m_t / 6) % 2;
      1:       return (m_t / 6) % 4;
      2, 3:    return m_t / 6;
      4:       return 0;
      default: return 1;
    endcase
  endfunction

  function automatic int exp_attack();
    return ((m_st == 2 && m_t / 6 == 1) || (m_st == 3 && m_t / 6 == 2)) ? 1 : 0;
  endfunction

  task automatic model_step();
    int dir;
    if (Reset) begin
      m_x = 100; m_y = 240; m_face = 0; m_st = 0; m_t = 0;
    end else if (frame_tick) begin
      dir = (move_left != move_right) ? (move_right ? 1 : -1) : 0;
      case (m_st)
        0, 1: begin
          if (jump)       begin m_st = 4; m_t = 0; end
          else if (punch) begin m_st = 2; m_t = 0; end
          else if (kick)  begin m_st = 3; m_t = 0; end
          else if (dir != 0) begin
            m_x = clampx(m_x + 4 * dir);
            m_face = (dir < 0) ? 1 : 0;
            if (m_st == 1) m_t++; else begin m_st = 1; m_t = 0; end
          end else begin
            if (m_st == 0) m_t++; else begin m_st = 0; m_t = 0; end
          end
        end
        2, 3: begin
          m_t++;
          if (m_t == ((m_st == 2) ? 3 : 4) * 6) begin m_st = 0; m_t = 0; end
        end
        4: begin
          m_x = clampx(m_x + 4 * dir);
          m_y = m_y - 8;
          if (m_y <= 144) begin m_y = 144; m_st = 5; m_t = 0; end
        end
        default: begin
          m_x = clampx(m_x + 4 * dir);
          m_y = m_y + 8;
          if (m_y >= 240) begin m_y = 240; m_st = 0; m_t = 0; end
        end
      endcase
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pin both the DUT and the model to a hand-derived value.
  task automatic pin(input string name, input int dut_v, input int mdl_v, input int lit);
    check(name, dut_v, lit);
    check({name, "/model"}, mdl_v, lit);
  endtask

  // One clock: drive inputs now, let the DUT sample them, then advance the model.
  task automatic cycle(input logic rst, input logic tk, input logic l, input logic r,
                       input logic p, input logic k, input logic j);
    Reset = rst; frame_tick = tk; move_left = l; move_right = r;
    punch = p; kick = k; jump = j;
    @(posedge vga_clk);
    #1;
    model_step();
    if (rst || tk)
      $display("[%0t] rst=%0b tick=%0b lrpkj=%0b%0b%0b%0b%0b -> st=%0d fr=%0d x=%0d y=%0d fl=%0b atk=%0b busy=%0b",
               $time, rst, tk, l, r, p, k, j, anim_state, anim_frame, AkumaX, AkumaY,
               facing_left, attack_active, busy);
  endtask

  // A frame tick followed by a quiet cycle with random command noise, which
  // must be ignored because no tick accompanies it.
  task automatic tick_cmd(input logic l, input logic r, input logic p, input logic k, input logic j);
    cycle(1'b0, 1'b1, l, r, p, k, j);
    cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge vga_clk) begin
    if (chk_en) begin
      check("AkumaX",        int'(AkumaX),        m_x);
      check("AkumaY",        int'(AkumaY),        m_y);
      check("facing_left",   int'(facing_left),   m_face);
      check("anim_state",    int'(anim_state),    m_st);
      check("anim_frame",    int'(anim_frame),    exp_frame());
      check("attack_active", int'(attack_active), exp_attack());
      check("busy",          int'(busy),          (m_st >= 2) ? 1 : 0);
    end
  end

  initial begin
    int left_exp [5];
    left_exp = '{4, 0, 0, 0, 0};

    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk_en = 1'b1;
    pin("rst_x",      int'(AkumaX),        m_x,      100);
    pin("rst_y",      int'(AkumaY),        m_y,      240);
    pin("rst_state",  int'(anim_state),    m_st,     0);
    pin("rst_face",   int'(facing_left),   m_face,   0);
    pin("rst_frame",  int'(anim_frame),    exp_frame(), 0);
    pin("rst_busy",   int'(busy),          (m_st >= 2) ? 1 : 0, 0);
    pin("rst_attack", int'(attack_active), exp_attack(), 0);

    // Walk right for 10 ticks, then release.
    for (int i = 0; i < 10; i++) tick_cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    pin("walk_x",     int'(AkumaX),      m_x,    140);
    pin("walk_state", int'(anim_state),  m_st,   1);
    pin("walk_face",  int'(facing_left), m_face, 0);
    tick_cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    pin("rel_state",  int'(anim_state),  m_st,   0);
    pin("rel_x",      int'(AkumaX),      m_x,    140);

    // Walk left down to X=8, then into the left wall.
    for (int i = 0; i < 33; i++) tick_cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    pin("left_x8", int'(AkumaX), m_x, 8);
    for (int i = 0; i < 5; i++) begin
      tick_cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      pin("left_clamp_x", int'(AkumaX), m_x, left_exp[i]);
    end
    pin("left_face", int'(facing_left), m_face, 1);

    // Walk right from 0 into the right wall.
    for (int i = 0; i < 124; i++) tick_cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    pin("right_x496", int'(AkumaX), m_x, 496);
    tick_cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    pin("right_x498", int'(AkumaX), m_x, 498);
    tick_cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    pin("right_hold", int'(AkumaX), m_x, 498);

    // Punch with move_right held throughout.
    do_reset();
    tick_cmd(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    pin("punch_entry", int'(anim_state), m_st, 2);
    for (int k = 1; k <= 18; k++) begin
      tick_cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      pin("punch_atk", int'(attack_active), exp_attack(), (k >= 6 && k <= 11) ? 1 : 0);
      pin("punch_state", int'(anim_state), m_st, (k < 18) ? 2 : 0);
    end
    pin("punch_x", int'(AkumaX), m_x, 100);

    // Kick: 24 ticks, hit window on frame 2.
    tick_cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    pin("kick_entry", int'(anim_state), m_st, 3);
    for (int k = 1; k <= 24; k++) begin
      tick_cmd(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      pin("kick_atk", int'(attack_active), exp_attack(), (k >= 12 && k <= 17) ? 1 : 0);
      pin("kick_state", int'(anim_state), m_st, (k < 24) ? 3 : 0);
    end

    // Face left, then jump with move_right held: facing stays locked.
    do_reset();
    tick_cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick_cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    pin("jump_entry_state", int'(anim_state), m_st, 4);
    pin("jump_entry_y",     int'(AkumaY),     m_y,  240);
    pin("jump_entry_x",     int'(AkumaX),     m_x,  96);
    for (int k = 1; k <= 24; k++) begin
      tick_cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      if (k == 12) begin
        pin("apex_y",     int'(AkumaY),     m_y,  144);
        pin("apex_state", int'(anim_state), m_st, 5);
      end
    end
    pin("land_y",     int'(AkumaY),      m_y,    240);
    pin("land_state", int'(anim_state),  m_st,   0);
    pin("land_x",     int'(AkumaX),      m_x,    192);
    pin("land_face",  int'(facing_left), m_face, 1);

    // Reset coinciding with a tick five ticks into a jump.
    do_reset();
    tick_cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 5; k++) tick_cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    pin("midjump_y", int'(AkumaY), m_y, 200);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    pin("abort_y",     int'(AkumaY),     m_y,  240);
    pin("abort_x",     int'(AkumaX),     m_x,  100);
    pin("abort_state", int'(anim_state), m_st, 0);
    pin("abort_busy",  int'(busy),       (m_st >= 2) ? 1 : 0, 0);

    // Both directions + jump + punch together: jump wins, no X motion.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick_cmd(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    pin("combo_state", int'(anim_state), m_st, 4);
    for (int k = 1; k <= 24; k++) tick_cmd(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    pin("combo_x",     int'(AkumaX),     m_x,  100);
    pin("combo_state_end", int'(anim_state), m_st, 0);

    // Randomized stream.
    for (int i = 0; i < 1500; i++) begin
      cycle(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 9) == 0));
    end

    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge vga_clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
